// File: rtl/counter_seq_pkg.sv
// Shared definitions for the run/pause/done counter sequencer.
package counter_seq_pkg;

  // Default counter and terminal-count width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // FSM states; the encodings are visible on the state output port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/cnt_core.sv
// Counting register: synchronous clear beats enable, wraps modulo 2^WIDTH.
module cnt_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Counter register: reset, then clear, then increment.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block evaluation order.
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/done sequencer around a cnt_core counter with a latched
// terminal count and one-shot / auto-reload modes.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_q;
  logic [WIDTH-1:0] tc_q;
  logic             mode_q;
  logic             match;
  logic             cnt_en;
  logic             cnt_clr;

  // Terminal-count comparator against the value latched at run start.
  assign match = (count == tc_q);
  assign state = state_q;

  // Counter control: clear on abort, start and auto-reload; count in RUN.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (clear) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: cnt_clr = start;
        RUN: begin
          if (match) begin
            cnt_clr = mode_q;
          end else begin
            cnt_en = !stop;
          end
        end
        PAUSE: begin
        end
      endcase
    end
  end

  // FSM with registered busy/done and the tc/mode latches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tc_q    <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (clear) begin
      // tc_q and mode_q are deliberately kept across an abort.
      state_q <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy    <= 1'b1;
            tc_q    <= tc;
            mode_q  <= mode;
          end
        end
        RUN: begin
          // Terminal completion outranks stop; start is ignored here.
          if (match) begin
            done <= 1'b1;
            if (!mode_q) begin
              state_q <= DONE;
              busy    <= 1'b0;
            end
          end else if (stop) begin
            state_q <= PAUSE;
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_q <= RUN;
          end
        end
      endcase
    end
  end

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt_core (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .q   (count)
  );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_counter_seq_ctrl;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         clear = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] tc    = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  int tests = 0;
  int fails = 0;

  // Behavioural model: run/pause/finished flags plus counter value.
  bit m_valid    = 0;
  bit m_running  = 0;
  bit m_paused   = 0;
  bit m_finished = 0;
  bit m_done     = 0;
  bit m_mode     = 0;
  int m_count    = 0;
  int m_tc       = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .clear (clear),
    .mode  (mode),
    .tc    (tc),
    .count (count),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int model_state();
    if (m_finished) return 3;
    if (m_paused)   return 2;
    if (m_running)  return 1;
    return 0;
  endfunction

  // Model update from the rules, using the inputs present at this edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1; m_running = 0; m_paused = 0; m_finished = 0;
      m_done = 0; m_count = 0; m_tc = 0; m_mode = 0;
    end else if (clear) begin
      m_running = 0; m_paused = 0; m_finished = 0; m_done = 0; m_count = 0;
    end else if (m_running) begin
      if (m_count == m_tc) begin
        m_done = 1;
        if (m_mode) m_count = 0;
        else begin m_running = 0; m_finished = 1; end
      end else if (stop) begin
        m_done = 0; m_running = 0; m_paused = 1;
      end else begin
        m_done = 0; m_count = (m_count + 1) % (1 << W);
      end
    end else if (m_paused) begin
      m_done = 0;
      if (start && !stop) begin m_paused = 0; m_running = 1; end
    end else begin
      m_done = 0;
      if (start) begin
        m_running = 1; m_finished = 0; m_count = 0; m_tc = int'(tc); m_mode = mode;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count", 32'(count), 32'(m_count));
      check("model_state", 32'(state), 32'(model_state()));
      check("model_done",  32'(done),  32'(m_done));
      check("model_busy",  32'(busy),  32'(m_running || m_paused));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with start asserted.
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_state", 32'(state), 0);
      check("rst_count", 32'(count), 0);
      check("rst_done",  32'(done),  0);
      check("rst_busy",  32'(busy),  0);
    end

    // One-shot, tc=5.
    rst = 1'b1; tc = 4'd5; mode = 1'b0;
    tick();
    check("os_start_state", 32'(state), 1);
    check("os_start_count", 32'(count), 0);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("os_count", 32'(count), 32'(k));
      check("os_nodone", 32'(done), 0);
    end
    tick();
    check("os_done", 32'(done), 1);
    check("os_done_state", 32'(state), 3);
    check("os_hold", 32'(count), 5);
    tick();
    check("os_done_once", 32'(done), 0);
    check("os_hold2", 32'(count), 5);

    // Auto-reload, tc=2.
    start = 1'b1; tc = 4'd2; mode = 1'b1;
    tick();
    check("ar_start_count", 32'(count), 0);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("ar_count", 32'(count), 32'(k % 3));
      check("ar_done",  32'(done),  32'((k % 3) == 0));
      check("ar_busy",  32'(busy),  1);
    end
    clear = 1'b1;
    tick();
    check("clr_state", 32'(state), 0);
    check("clr_count", 32'(count), 0);
    clear = 1'b0;

    // Pause / resume, tc=9.
    start = 1'b1; tc = 4'd9; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pr_count3", 32'(count), 3);
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pr_pause_state", 32'(state), 2);
      check("pr_pause_count", 32'(count), 3);
    end
    stop = 1'b0; start = 1'b1;
    tick();
    check("pr_resume_state", 32'(state), 1);
    check("pr_resume_count", 32'(count), 3);
    start = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      tick();
      check("pr_count", 32'(count), 32'(k));
    end
    tick();
    check("pr_done", 32'(done), 1);
    check("pr_done_state", 32'(state), 3);

    // Clear colliding with start at count 6.
    start = 1'b1; tc = 4'd10; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("col_count6", 32'(count), 6);
    clear = 1'b1; start = 1'b1;
    tick();
    check("col_clr_state", 32'(state), 0);
    check("col_clr_count", 32'(count), 0);
    check("col_clr_done",  32'(done),  0);
    clear = 1'b0; start = 1'b0;

    // Terminal match together with stop at tc=4.
    start = 1'b1; tc = 4'd4; mode = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    stop = 1'b1;
    tick();
    check("col_stop_done",  32'(done),  1);
    check("col_stop_state", 32'(state), 3);
    stop = 1'b0;

    // Reset in the middle of an auto-reload run.
    start = 1'b1; tc = 4'd8; mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("col_rst_state", 32'(state), 0);
    check("col_rst_count", 32'(count), 0);
    check("col_rst_done",  32'(done),  0);
    rst = 1'b1;

    // Wrap at the full counter range, tc=15 auto-reload.
    start = 1'b1; tc = 4'd15; mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("wrap_count15", 32'(count), 15);
    tick();
    check("wrap_count0", 32'(count), 0);
    check("wrap_done",   32'(done),  1);
    tick();
    check("wrap_count1", 32'(count), 1);
    check("wrap_done_off", 32'(done), 0);

    // Random stimulus, checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 63) != 0);
      clear = ($urandom_range(0, 31) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 5) == 0);
      mode  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) tc = 4'($urandom_range(0, 1));
      else                           tc = 4'($urandom_range(0, 15));
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, counter and terminal-count width in bits.
REQ-002 Port: clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 Port: start  in  1  level; begins a run from IDLE/DONE, or resumes from PAUSE.
REQ-005 Port: stop  in  1  level; pauses a run in RUN.
REQ-006 Port: clear  in  1  level; aborts to IDLE from any state.
REQ-007 Port: mode  in  1  0 = one-shot, 1 = auto-reload; latched with tc on run start.
REQ-008 Port: tc  in  WIDTH  terminal count; latched into tc_q when a run starts.
REQ-009 Port: count  out  WIDTH  current counter value, registered.
REQ-010 Port: busy  out  1  high in RUN or PAUSE.
REQ-011 Port: done  out  1  registered one-cycle pulse when terminal count is reached.
REQ-012 Port: state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with the encodings listed in REQ-012.
REQ-014 Priority at each edge SHALL be: clear > terminal-count completion > stop > start.
REQ-015 In IDLE or DONE with start=1: go to RUN, count<=0, latch tc_q<=tc and mode_q<=mode.
REQ-016 In RUN with count!=tc_q: count<=count+1 (modulo 2^WIDTH).
- Unsigned arithmetic; no saturation.
REQ-017 In RUN with count==tc_q: done<=1 for exactly one cycle.
- mode_q=0: go to DONE, count holds tc_q.
- mode_q=1: stay in RUN, count<=0.
REQ-018 Start-to-done latency: start sampled at edge 0 SHALL give count=k after edge k and done=1 in the cycle after edge tc_q+1.
REQ-019 tc_q=0 in auto-reload mode SHALL assert done every cycle from the second RUN edge onward, with count stuck at 0.
REQ-020 In RUN with stop=1 and no terminal match: go to PAUSE, count holds.
REQ-021 In RUN, a terminal match and stop in the same cycle SHALL complete the terminal action and ignore stop.
REQ-022 start in RUN SHALL be ignored; no restart.
REQ-023 PAUSE transitions:
- start=1 and stop=0: go to RUN; count resumes from its held value, tc_q/mode_q unchanged.
- start=1 and stop=1: stay in PAUSE.
REQ-024 DONE SHALL hold count=tc_q and done=0 until start or clear.
REQ-025 clear=1 in any state: go to IDLE, count<=0, done<=0; tc_q is retained.
REQ-026 Changes on tc/mode while busy SHALL NOT affect the current run.
REQ-027 done SHALL never be high for two consecutive cycles, except under auto-reload with tc_q=0.

Reset
REQ-028 rst=0 at a rising edge SHALL force state=IDLE, count=0, done=0, tc_q=0, mode_q=0, busy=0.
- Reset overrides clear/start/stop.
REQ-029 Reset asserted mid-run SHALL abort it, with no done pulse in the cycle after reset.
REQ-030 All outputs SHALL be valid (reset values) from the first edge with rst=0; there is no asynchronous path.

Structure
REQ-031 Shared package counter_seq_pkg SHALL hold:
- the state enum/localparams (IDLE/RUN/PAUSE/DONE encodings);
- the default WIDTH constant.
REQ-032 The counting register SHALL be a sub-module cnt_core with:
- ports clk, rst (sync active-low), en, clr, q[WIDTH-1:0];
- behaviour: clr beats en, q increments when en=1.
REQ-033 counter_seq_ctrl SHALL contain only:
- the FSM;
- the tc_q/mode_q latches;
- the comparator;
- the done register;
- cnt_core control.

Verification
REQ-034 Reset: rst=0 for 2 cycles with start=1 -> state=00, count=0, done=0, busy=0 throughout.
REQ-035 One-shot: tc=5, mode=0, start pulsed 1 cycle ->
- count 0..5 on successive edges;
- done=1 for one cycle after the 7th edge;
- state=11, count holds 5.
REQ-036 Auto-reload: tc=2, mode=1, start pulsed ->
- count sequence 0,1,2,0,1,2;
- done pulses every 3 cycles;
- busy stays 1.
REQ-037 Pause/resume: tc=9, stop at count=3 for 4 cycles, then start -> count holds 3 while state=10, then continues 4..9; done 10 RUN edges after the initial start.
REQ-038 Collisions:
- clear with start at count=6 -> IDLE, count=0, no done;
- terminal match with stop at count==tc=4 -> done=1, state=11;
- rst=0 mid-run -> IDLE next cycle.
REQ-039 Wrap: WIDTH=4, tc=15, mode=1 -> count 15 then 0, with a done pulse at each wrap.
